// File: rtl/score_keeper_pkg.sv
// Shared constants and state encoding for the score keeper and its
// display helpers.
package score_keeper_pkg;

  localparam int DEF_SCORE_W       = 14;
  localparam int DEF_SCORE_MAX     = 9999;
  localparam int DEF_LEVEL_W       = 4;
  localparam int DEF_PTS_PER_LEVEL = 20;
  localparam int DEF_MAX_STREAK    = 3;
  localparam int DEF_NUM_DIGITS    = 4;
  localparam int MAX_LINES         = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    CONVERT = 1'b1
  } state_t;

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: start loads bin, busy stays high for BIN_W cycles,
// done marks the final busy cycle and bcd updates on the edge that ends it.
module bin2bcd_serial #(
  parameter int BIN_W      = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0]        shift_q;
  logic [4*NUM_DIGITS-1:0] work_q;
  logic [4*NUM_DIGITS-1:0] adj;
  logic [4*NUM_DIGITS-1:0] work_next;
  logic [CNT_W-1:0]        cnt_q;

  always_comb begin
    adj = work_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
    end
    work_next = {adj[4*NUM_DIGITS-2:0], shift_q[BIN_W-1]};
    done      = busy & (cnt_q == CNT_W'(1));
  end

  // A start while busy restarts from scratch; bcd keeps the last finished result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      bcd     <= '0;
    end else if (start) begin
      shift_q <= bin;
      work_q  <= '0;
      cnt_q   <= CNT_W'(BIN_W);
      busy    <= 1'b1;
    end else if (busy) begin
      shift_q <= shift_q << 1;
      work_q  <= work_next;
      cnt_q   <= cnt_q - CNT_W'(1);
      if (done) begin
        busy <= 1'b0;
        bcd  <= work_next;
      end
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Game score keeper: streak bonus, saturating score, divider-free level
// tracking, high score and a serially converted BCD view of the score.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int SCORE_W       = DEF_SCORE_W,
  parameter int SCORE_MAX     = DEF_SCORE_MAX,
  parameter int LEVEL_W       = DEF_LEVEL_W,
  parameter int PTS_PER_LEVEL = DEF_PTS_PER_LEVEL,
  parameter int MAX_STREAK    = DEF_MAX_STREAK,
  parameter int NUM_DIGITS    = DEF_NUM_DIGITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr_valid,
  input  logic [2:0]                        clr_lines,
  output logic                              clr_ready,
  input  logic                              game_over,
  input  logic [LEVEL_W-1:0]                debug_level,
  output logic [SCORE_W-1:0]                score,
  output logic [$clog2(MAX_STREAK+1)-1:0]   streak,
  output logic [LEVEL_W-1:0]                level,
  output logic [SCORE_W-1:0]                hi_score,
  output logic [4*NUM_DIGITS-1:0]           bcd,
  output logic                              bcd_valid
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int REM_W    = $clog2(2 * PTS_PER_LEVEL);
  localparam int DW       = SCORE_W + 1;
  localparam logic [DW-1:0]      SCORE_CEIL = DW'(SCORE_MAX);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP  = '1;

  state_t              state;
  logic [REM_W-1:0]    rem;
  logic [LEVEL_W-1:0]  base_level;

  logic                accept;
  logic [2:0]          eff_lines;
  logic [DW-1:0]       delta;
  logic [DW-1:0]       score_sum;
  logic [SCORE_W-1:0]  score_next;
  logic [SCORE_W-1:0]  applied;
  logic [REM_W-1:0]    rem_sum;
  logic                level_up;
  logic [STREAK_W-1:0] streak_next;
  logic [LEVEL_W:0]    level_sum;
  logic                conv_start;
  logic [SCORE_W-1:0]  conv_bin;
  logic                conv_busy;
  logic                conv_done;

  // Lines are clamped so one event can never add a full level's worth of
  // points, which keeps the single-subtract remainder update exact.
  always_comb begin
    clr_ready   = (state == IDLE) & ~game_over;
    accept      = clr_valid & clr_ready;
    eff_lines   = (clr_lines > 3'(MAX_LINES)) ? 3'(MAX_LINES) : clr_lines;
    delta       = (eff_lines == 3'd0) ? '0 : DW'(eff_lines) + DW'(streak);
    score_sum   = {1'b0, score} + delta;
    score_next  = (score_sum > SCORE_CEIL) ? SCORE_CEIL[SCORE_W-1:0] : score_sum[SCORE_W-1:0];
    applied     = score_next - score;
    rem_sum     = rem + REM_W'(applied);
    level_up    = rem_sum >= REM_W'(PTS_PER_LEVEL);
    if (eff_lines == 3'd0)                     streak_next = '0;
    else if (streak == STREAK_W'(MAX_STREAK))  streak_next = streak;
    else                                       streak_next = streak + STREAK_W'(1);
    level_sum   = {1'b0, base_level} + {1'b0, debug_level};
    level       = level_sum[LEVEL_W] ? base_level : level_sum[LEVEL_W-1:0];
    conv_start  = accept | game_over;
    conv_bin    = game_over ? '0 : score_next;
  end

  bin2bcd_serial #(
    .BIN_W      (SCORE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (conv_bin),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // game_over outranks everything and (re)starts a conversion of the cleared score.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      score      <= '0;
      streak     <= '0;
      rem        <= '0;
      base_level <= '0;
      hi_score   <= '0;
      bcd_valid  <= 1'b1;
    end else if (game_over) begin
      if (score > hi_score) hi_score <= score;
      score      <= '0;
      streak     <= '0;
      rem        <= '0;
      base_level <= '0;
      state      <= CONVERT;
      bcd_valid  <= 1'b0;
    end else if (accept) begin
      score  <= score_next;
      streak <= streak_next;
      if (level_up) begin
        rem <= rem_sum - REM_W'(PTS_PER_LEVEL);
        if (base_level != LEVEL_TOP) base_level <= base_level + LEVEL_W'(1);
      end else begin
        rem <= rem_sum;
      end
      state     <= CONVERT;
      bcd_valid <= 1'b0;
    end else if (state == CONVERT && conv_busy && conv_done) begin
      state     <= IDLE;
      bcd_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Scoreboard bench for score_keeper: expected results are queued when an
// event is offered and compared when the BCD conversion completes.
module tb_score_keeper;

  localparam int SCORE_W    = 14;
  localparam int SCORE_MAX  = 9999;
  localparam int LEVEL_W    = 4;
  localparam int PPL        = 20;
  localparam int MAX_STREAK = 3;
  localparam int LEVEL_TOP  = 15;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 clr_valid = 1'b0;
  logic [2:0]           clr_lines = '0;
  logic                 clr_ready;
  logic                 game_over = 1'b0;
  logic [LEVEL_W-1:0]   debug_level = '0;
  logic [SCORE_W-1:0]   score;
  logic [1:0]           streak;
  logic [LEVEL_W-1:0]   level;
  logic [SCORE_W-1:0]   hi_score;
  logic [15:0]          bcd;
  logic                 bcd_valid;

  score_keeper dut (
    .clk         (clk),
    .rst         (rst),
    .clr_valid   (clr_valid),
    .clr_lines   (clr_lines),
    .clr_ready   (clr_ready),
    .game_over   (game_over),
    .debug_level (debug_level),
    .score       (score),
    .streak      (streak),
    .level       (level),
    .hi_score    (hi_score),
    .bcd         (bcd),
    .bcd_valid   (bcd_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          score;
    int          streak;
    logic [15:0] bcd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_score = 0, m_streak = 0, m_rem = 0, m_base = 0, m_hi = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic model_accept(input int lines);
    int delta, ns, applied;
    exp_t e;
    delta = (lines == 0) ? 0 : lines + m_streak;
    ns = m_score + delta;
    if (ns > SCORE_MAX) ns = SCORE_MAX;
    applied = ns - m_score;
    m_rem = m_rem + applied;
    if (m_rem >= PPL) begin
      m_rem = m_rem - PPL;
      if (m_base < LEVEL_TOP) m_base++;
    end
    if (lines == 0) m_streak = 0;
    else if (m_streak < MAX_STREAK) m_streak++;
    m_score = ns;
    e.score = m_score; e.streak = m_streak; e.bcd = to_bcd(m_score);
    sb.push_back(e);
  endtask

  task automatic model_game_over();
    exp_t e;
    if (m_score > m_hi) m_hi = m_score;
    m_score = 0; m_streak = 0; m_rem = 0; m_base = 0;
    e.score = 0; e.streak = 0; e.bcd = 16'h0000;
    sb.push_back(e);
  endtask

  task automatic offer_event(input int lines);
    clr_lines = 3'(lines);
    clr_valid = 1'b1;
    @(posedge clk); #1;
    clr_valid = 1'b0;
    model_accept(lines);
  endtask

  task automatic wait_bcd(output int cyc, output bit ready_seen);
    cyc = 0;
    ready_seen = 1'b0;
    while (!bcd_valid && cyc < SCORE_W + 8) begin
      if (clr_ready) ready_seen = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bcd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL in_reset_bcd_valid got %b want 1", bcd_valid); end
    n_cmp++; if (score !== '0) begin n_bad++; $display("[TB] FAIL in_reset_score got %0d want 0", score); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (score !== '0) begin n_bad++; $display("[TB] FAIL reset_score got %0d want 0", score); end
    n_cmp++; if (bcd !== 16'h0000) begin n_bad++; $display("[TB] FAIL reset_bcd got %h want 0000", bcd); end
    n_cmp++; if (bcd_valid !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_bcd_valid got %b want 1", bcd_valid); end
    n_cmp++; if (clr_ready !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_clr_ready got %b want 1", clr_ready); end
    n_cmp++; if (hi_score !== '0 || streak !== '0 || level !== '0) begin
      n_bad++; $display("[TB] FAIL reset_misc got hi=%0d streak=%0d level=%0d want 0/0/0", hi_score, streak, level);
    end
  endtask

  task automatic test_streak();
    int lines_t[5]  = '{1, 1, 1, 1, 0};
    int score_t[5]  = '{1, 3, 6, 10, 10};
    int streak_t[5] = '{1, 2, 3, 3, 0};
    int cyc;
    bit rs;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      offer_event(lines_t[i]);
      n_cmp++; if (score !== SCORE_W'(score_t[i])) begin n_bad++; $display("[TB] FAIL streak_score[%0d] got %0d want %0d", i, score, score_t[i]); end
      n_cmp++; if (streak !== 2'(streak_t[i])) begin n_bad++; $display("[TB] FAIL streak_value[%0d] got %0d want %0d", i, streak, streak_t[i]); end
      wait_bcd(cyc, rs);
      n_cmp++; if (cyc != SCORE_W || rs) begin n_bad++; $display("[TB] FAIL streak_busy[%0d] got %0d cycles ready_seen=%b want %0d cycles ready_seen=0", i, cyc, rs, SCORE_W); end
      if (sb.size() == 0) begin n_cmp++; n_bad++; $display("[TB] FAIL streak_sb[%0d] got empty queue want entry", i); end
      else begin
        e = sb.pop_front();
        n_cmp++; if (bcd !== e.bcd || score !== SCORE_W'(e.score)) begin n_bad++; $display("[TB] FAIL streak_bcd[%0d] got bcd=%h score=%0d want bcd=%h score=%0d", i, bcd, score, e.bcd, e.score); end
      end
    end
  endtask

  task automatic test_level();
    int lines_t[3] = '{4, 3, 1};
    int score_t[3] = '{14, 18, 21};
    int cyc;
    bit rs;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      offer_event(lines_t[i]);
      n_cmp++; if (score !== SCORE_W'(score_t[i])) begin n_bad++; $display("[TB] FAIL level_score[%0d] got %0d want %0d", i, score, score_t[i]); end
      wait_bcd(cyc, rs);
      e = sb.pop_front();
      n_cmp++; if (bcd !== e.bcd || cyc != SCORE_W) begin n_bad++; $display("[TB] FAIL level_bcd[%0d] got %h after %0d want %h after %0d", i, bcd, cyc, e.bcd, SCORE_W); end
      n_cmp++; if (level !== LEVEL_W'(m_base)) begin n_bad++; $display("[TB] FAIL level_base[%0d] got %0d want %0d", i, level, m_base); end
    end
    n_cmp++; if (dut.rem !== 6'(m_rem) || m_rem != 1) begin n_bad++; $display("[TB] FAIL level_rem got %0d want 1", dut.rem); end
    debug_level = 4'd15; #1;
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("[TB] FAIL level_dbg15 got %0d want 1", level); end
    debug_level = 4'd3; #1;
    n_cmp++; if (level !== 4'd4) begin n_bad++; $display("[TB] FAIL level_dbg3 got %0d want 4", level); end
    debug_level = 4'd0; #1;
  endtask

  task automatic test_game_over();
    int cyc;
    bit rs;
    exp_t e;
    offer_event(1);
    n_cmp++; if (score !== SCORE_W'(25)) begin n_bad++; $display("[TB] FAIL go_pre_score got %0d want 25", score); end
    repeat (4) @(posedge clk);
    #1;
    game_over = 1'b1; clr_valid = 1'b1; clr_lines = 3'd2;
    #1;
    n_cmp++; if (clr_ready !== 1'b0) begin n_bad++; $display("[TB] FAIL go_ready got %b want 0", clr_ready); end
    @(posedge clk); #1;
    game_over = 1'b0; clr_valid = 1'b0;
    void'(sb.pop_back());
    model_game_over();
    n_cmp++; if (score !== '0 || streak !== '0) begin n_bad++; $display("[TB] FAIL go_clear got score=%0d streak=%0d want 0/0", score, streak); end
    n_cmp++; if (hi_score !== SCORE_W'(m_hi) || m_hi != 25) begin n_bad++; $display("[TB] FAIL go_hi got %0d want 25", hi_score); end
    n_cmp++; if (bcd !== 16'h0021 || bcd_valid !== 1'b0) begin n_bad++; $display("[TB] FAIL go_hold got bcd=%h valid=%b want 0021/0", bcd, bcd_valid); end
    wait_bcd(cyc, rs);
    e = sb.pop_front();
    n_cmp++; if (cyc != SCORE_W || bcd !== e.bcd) begin n_bad++; $display("[TB] FAIL go_bcd got %h after %0d want %h after %0d", bcd, cyc, e.bcd, SCORE_W); end
    n_cmp++; if (score !== '0 || level !== '0) begin n_bad++; $display("[TB] FAIL go_unaccepted got score=%0d level=%0d want 0/0", score, level); end
  endtask

  task automatic test_saturation();
    int cyc, r, lines, guard;
    bit rs;
    exp_t e;
    guard = 0;
    while ((m_score < SCORE_MAX - 2 || m_streak != 0) && guard < 5000) begin
      r = (SCORE_MAX - 2) - m_score;
      if (1 + m_streak > r) lines = 0;
      else lines = (r - m_streak > 4) ? 4 : r - m_streak;
      offer_event(lines);
      wait_bcd(cyc, rs);
      e = sb.pop_front();
      n_cmp++; if (bcd !== e.bcd || score !== SCORE_W'(e.score) || cyc != SCORE_W) begin
        n_bad++; $display("[TB] FAIL ramp got score=%0d bcd=%h cyc=%0d want score=%0d bcd=%h cyc=%0d", score, bcd, cyc, e.score, e.bcd, SCORE_W);
      end
      guard++;
    end
    n_cmp++; if (score !== SCORE_W'(9997) || streak !== '0) begin n_bad++; $display("[TB] FAIL sat_start got score=%0d streak=%0d want 9997/0", score, streak); end
    for (int i = 0; i < 2; i++) begin
      offer_event(4);
      wait_bcd(cyc, rs);
      e = sb.pop_front();
      n_cmp++; if (score !== SCORE_W'(9999) || bcd !== 16'h9999 || bcd !== e.bcd) begin
        n_bad++; $display("[TB] FAIL sat_top[%0d] got score=%0d bcd=%h want 9999/9999", i, score, bcd);
      end
    end
    n_cmp++; if (level !== LEVEL_W'(m_base) || m_base != LEVEL_TOP) begin n_bad++; $display("[TB] FAIL sat_level got %0d want %0d", level, LEVEL_TOP); end
    debug_level = 4'd3; #1;
    n_cmp++; if (level !== 4'd15) begin n_bad++; $display("[TB] FAIL sat_level_dbg got %0d want 15", level); end
    debug_level = 4'd0;
    game_over = 1'b1;
    @(posedge clk); #1;
    game_over = 1'b0;
    model_game_over();
    n_cmp++; if (hi_score !== SCORE_W'(m_hi) || score !== '0) begin n_bad++; $display("[TB] FAIL sat_hi got hi=%0d score=%0d want %0d/0", hi_score, score, m_hi); end
    wait_bcd(cyc, rs);
    e = sb.pop_front();
    n_cmp++; if (bcd !== e.bcd) begin n_bad++; $display("[TB] FAIL sat_go_bcd got %h want %h", bcd, e.bcd); end
  endtask

  task automatic test_reset_mid_convert();
    offer_event(2);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    n_cmp++; if (score !== '0 || bcd !== 16'h0000 || bcd_valid !== 1'b1 || hi_score !== '0) begin
      n_bad++; $display("[TB] FAIL mid_reset got score=%0d bcd=%h valid=%b hi=%0d want 0/0000/1/0", score, bcd, bcd_valid, hi_score);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    m_score = 0; m_streak = 0; m_rem = 0; m_base = 0; m_hi = 0;
    for (int i = 0; i < SCORE_W + 2; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (bcd_valid !== 1'b1 || clr_ready !== 1'b1 || bcd !== 16'h0000) begin
        n_bad++; $display("[TB] FAIL post_reset[%0d] got valid=%b ready=%b bcd=%h want 1/1/0000", i, bcd_valid, clr_ready, bcd);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_streak();
    test_level();
    test_game_over();
    test_saturation();
    test_reset_mid_convert();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 The block SHALL have parameter SCORE_W, default 14, giving the score register width.
REQ-002 The block SHALL have parameter SCORE_MAX, default 9999, giving the saturation ceiling; it SHALL satisfy SCORE_MAX < 2^SCORE_W.
REQ-003 The block SHALL have parameter LEVEL_W, default 4, giving the level width; the maximum level is 2^LEVEL_W-1.
REQ-004 The block SHALL have parameter PTS_PER_LEVEL, default 20, giving score points per level; it SHALL be greater than 4+MAX_STREAK.
REQ-005 The block SHALL have parameter MAX_STREAK, default 3, giving the streak bonus cap.
REQ-006 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of BCD display digits.
REQ-007 The block SHALL have the following ports:
- clk  in  1  system clock; all registers on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clr_valid  in  1  clear-result event offered.
- clr_lines  in  3  lines cleared by the event (0..4).
- clr_ready  out  1  event accepted when clr_valid & clr_ready.
- game_over  in  1  single-cycle game-over pulse.
- debug_level  in  LEVEL_W  level offset from switches.
- score  out  SCORE_W  current score.
- streak  out  $clog2(MAX_STREAK+1)  consecutive-clear count.
- level  out  LEVEL_W  effective level.
- hi_score  out  SCORE_W  best score since reset.
- bcd  out  4*NUM_DIGITS  BCD of score; digit 0 is least significant.
- bcd_valid  out  1  bcd matches score.

Function
REQ-008 The block SHALL implement FSM states IDLE and CONVERT.
REQ-009 clr_ready SHALL equal (state==IDLE) & ~game_over.
REQ-010 On acceptance, delta SHALL be 0 if clr_lines==0, else clr_lines+streak.
REQ-011 On acceptance, score SHALL become min(score+delta, SCORE_MAX), registered one cycle after acceptance.
REQ-012 On acceptance, streak SHALL become 0 if clr_lines==0, else min(streak+1, MAX_STREAK).
REQ-013 The level counter SHALL be divider-free: remainder rem += applied delta; if rem >= PTS_PER_LEVEL, then rem -= PTS_PER_LEVEL and base_level increments, saturating at 2^LEVEL_W-1.
REQ-014 The applied delta SHALL be the post-saturation score increase.
REQ-015 level SHALL be combinational: base_level+debug_level if that sum is <= 2^LEVEL_W-1, else base_level.
REQ-016 Every acceptance SHALL move the FSM to CONVERT, even when delta is 0.
REQ-017 On entering CONVERT, bcd_valid SHALL fall and a serial double-dabble of the new score SHALL run, one bit per cycle, SCORE_W cycles.
REQ-018 On the final CONVERT cycle, bcd SHALL load, bcd_valid SHALL rise, and the FSM SHALL return to IDLE.
REQ-019 bcd SHALL hold its previous value throughout CONVERT.
REQ-020 Latency from acceptance at cycle N SHALL be: score valid at N+1, bcd_valid high at N+1+SCORE_W.
REQ-021 game_over SHALL be honoured in any state and SHALL take priority over a simultaneous clr_valid; that event is not accepted.
REQ-022 On game_over, hi_score SHALL become max(hi_score, score), and score, streak, rem and base_level SHALL clear.
REQ-023 On game_over, the FSM SHALL enter or restart CONVERT, aborting any conversion in progress.
REQ-024 Values above SCORE_MAX SHALL be unreachable, and BCD digits SHALL be 0..9.

Reset
REQ-025 While rst is low, state SHALL be IDLE and score, streak, rem, base_level, hi_score and bcd SHALL be 0.
REQ-026 While rst is low, bcd_valid SHALL be 1.
REQ-027 Reset mid-CONVERT SHALL discard the conversion.

Structure
REQ-028 Parameter defaults, the FSM state encoding and MAX_LINES=4 SHALL reside in the shared header.
REQ-029 The double-dabble SHALL be a sub-module, bin2bcd_serial (start/busy/done handshake), reusable by other display blocks.

Verification
REQ-030 After reset, with no events, the bench SHALL see score=0, bcd=0x0000, bcd_valid=1 and clr_ready=1.
REQ-031 Accepted clr_lines 1,1,1,1,0 SHALL yield scores 1,3,6,10,10 and streaks 1,2,3,3,0, with clr_ready low SCORE_W cycles after each event.
REQ-032 Events raising score from 18 to 21 SHALL give base_level=1 and rem=1.
REQ-033 With debug_level=15 and base_level=1, level SHALL be 1; with debug_level=3, level SHALL be 4.
REQ-034 From score=9997, an accepted clr_lines=4 with streak=0 SHALL yield score=9999 and bcd=0x9999.
REQ-035 game_over in cycle 5 of a CONVERT SHALL set hi_score to the prior score and score to 0, give bcd=0x0000 SCORE_W cycles later, and leave a simultaneous clr_valid unaccepted.
